lr_sc_rsv_unit: RTL and testbench



---
 rtl/lr_sc_rsv_unit.sv | 109 ++++++++++
 tb/tb_lr_sc_rsv_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lr_sc_rsv_unit.sv
// LR/SC reservation unit: one reservation per requester ID, killed by snooped
// stores, SC clears, or an optional lifetime counter. The SC result is registered.
module lr_sc_rsv_unit #(
  parameter int ADDR_WIDTH   = 32,
  parameter int N_IDS        = 2,
  parameter int GRANULE_LOG2 = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_lr,
  input  logic                     i_sc,
  input  logic [$clog2(N_IDS)-1:0] i_id,
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  input  logic                     i_wr_en,
  input  logic [ADDR_WIDTH-1:0]    i_wr_addr,
  output logic                     o_sc_done,
  output logic                     o_sc_gnt,
  output logic [N_IDS-1:0]         o_rsv_valid
);
  localparam int IDW = $clog2(N_IDS);
  localparam int TW  = ADDR_WIDTH - GRANULE_LOG2;
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [N_IDS-1:0]         valid_q, valid_d;
  logic [N_IDS-1:0][TW-1:0] tag_q, tag_d;
  logic [N_IDS-1:0]         kill, ld, expire;
  logic [TW-1:0]            req_tag, wr_tag;
  logic                     sc_done_q, sc_gnt_q, gnt;

  assign req_tag = i_addr[ADDR_WIDTH-1:GRANULE_LOG2];
  assign wr_tag  = i_wr_addr[ADDR_WIDTH-1:GRANULE_LOG2];

  if (GRANULE_LOG2 > 0) begin : g_gran
    logic unused_low;
    assign unused_low = ^{i_addr[GRANULE_LOG2-1:0], i_wr_addr[GRANULE_LOG2-1:0]};
  end

  // LR is ignored when it collides with an SC in the same cycle.
  always_comb begin
    kill = '0;
    ld   = '0;
    for (int e = 0; e < N_IDS; e++) begin
      kill[e] = i_wr_en && valid_q[e] && (tag_q[e] == wr_tag);
      ld[e]   = i_lr && !i_sc && (i_id == IDW'(e));
    end
  end

  assign gnt = valid_q[i_id] && (tag_q[i_id] == req_tag) && !kill[i_id];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    for (int e = 0; e < N_IDS; e++) begin
      if (i_sc && (i_id == IDW'(e))) begin
        valid_d[e] = 1'b0;
      end else if (ld[e]) begin
        valid_d[e] = 1'b1;
        tag_d[e]   = req_tag;
      end else if (kill[e] || expire[e]) begin
        valid_d[e] = 1'b0;
      end
    end
  end

  if (TIMEOUT > 0) begin : g_to
    logic [N_IDS-1:0][CW-1:0] cnt_q, cnt_d;

    // Expire when the counter reads 1: the entry then lives exactly TIMEOUT cycles.
    always_comb begin
      cnt_d  = cnt_q;
      expire = '0;
      for (int e = 0; e < N_IDS; e++) begin
        expire[e] = valid_q[e] && (cnt_q[e] == CW'(1));
        if (ld[e])           cnt_d[e] = CW'(TIMEOUT);
        else if (valid_q[e]) cnt_d[e] = cnt_q[e] - CW'(1);
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
  end else begin : g_noto
    assign expire = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q   <= '0;
      tag_q     <= '0;
      sc_done_q <= 1'b0;
      sc_gnt_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      sc_done_q <= i_sc;
      sc_gnt_q  <= i_sc && gnt;
    end
  end

  always @(posedge i_clk) begin
    if (!i_rst) assert (!(i_lr && i_sc));
  end

  assign o_sc_done   = sc_done_q;
  assign o_sc_gnt    = sc_gnt_q;
  assign o_rsv_valid = valid_q;
endmodule

// File: tb/tb_lr_sc_rsv_unit.sv
// Bench for lr_sc_rsv_unit: SC results go through a scoreboard queue; a second
// instance with a short lifetime covers expiry.
module tb_lr_sc_rsv_unit;
  logic        clk = 1'b0;
  logic        i_rst = 1'b0, i_lr = 1'b0, i_sc = 1'b0, i_wr_en = 1'b0;
  logic        i_id = 1'b0;
  logic [31:0] i_addr = '0, i_wr_addr = '0;
  logic        done, gnt, t_done, t_gnt;
  logic [1:0]  rv, t_rv;

  bit q[$];
  int n_chk = 0, n_pass = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  lr_sc_rsv_unit #(.ADDR_WIDTH(32), .N_IDS(2), .GRANULE_LOG2(2), .TIMEOUT(64)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_lr(i_lr), .i_sc(i_sc), .i_id(i_id), .i_addr(i_addr),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .o_sc_done(done), .o_sc_gnt(gnt), .o_rsv_valid(rv));

  lr_sc_rsv_unit #(.ADDR_WIDTH(32), .N_IDS(2), .GRANULE_LOG2(2), .TIMEOUT(4)) dut_t (
    .i_clk(clk), .i_rst(i_rst), .i_lr(i_lr), .i_sc(i_sc), .i_id(i_id), .i_addr(i_addr),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .o_sc_done(t_done), .o_sc_gnt(t_gnt), .o_rsv_valid(t_rv));

  // Scoreboard consumer for the main instance.
  initial begin
    bit exp;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n_chk++;
        if (q.size() > 0) begin
          exp = q.pop_front();
          if (done === 1'b1 && gnt === exp) n_pass++;
          else $display("FAIL sc_result got done=%b gnt=%b want done=1 gnt=%b", done, gnt, exp);
        end else begin
          if (done === 1'b0 && gnt === 1'b0) n_pass++;
          else $display("FAIL sc_idle got done=%b gnt=%b want done=0 gnt=0", done, gnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic lr(input logic id_v, input logic [31:0] a);
    i_lr = 1'b1; i_id = id_v; i_addr = a;
    tick();
    i_lr = 1'b0;
  endtask

  task automatic sc(input logic id_v, input logic [31:0] a, input bit exp);
    i_sc = 1'b1; i_id = id_v; i_addr = a;
    tick();
    q.push_back(exp);
    i_sc = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    n_chk++;
    if ({done, gnt, rv, t_rv} !== 6'b0) $display("FAIL reset got %b want 000000", {done, gnt, rv, t_rv});
    else n_pass++;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    lr(1'b0, 32'h1000);
    tick(); tick();
    sc(1'b0, 32'h1000, 1'b1);
    n_chk++;
    if (rv[0] !== 1'b0) $display("FAIL basic_clear got %b want 0", rv[0]); else n_pass++;
    sc(1'b0, 32'h1000, 1'b0);
  endtask

  task automatic test_granule();
    lr(1'b1, 32'h2000);
    sc(1'b1, 32'h2003, 1'b1);
    lr(1'b1, 32'h2000);
    sc(1'b1, 32'h2004, 1'b0);
    n_chk++;
    if (rv[1] !== 1'b0) $display("FAIL granule_clear got %b want 0", rv[1]); else n_pass++;
  endtask

  task automatic test_snoop();
    lr(1'b0, 32'h3000);
    lr(1'b1, 32'h3000);
    n_chk++;
    if (rv !== 2'b11) $display("FAIL snoop_pre got %b want 11", rv); else n_pass++;
    i_wr_en = 1'b1; i_wr_addr = 32'h3002;
    tick();
    i_wr_en = 1'b0;
    n_chk++;
    if (rv !== 2'b00) $display("FAIL snoop_kill got %b want 00", rv); else n_pass++;
    sc(1'b0, 32'h3000, 1'b0);
    lr(1'b0, 32'h3000);
    i_sc = 1'b1; i_id = 1'b0; i_addr = 32'h3000; i_wr_en = 1'b1; i_wr_addr = 32'h3000;
    tick();
    q.push_back(1'b0);
    i_sc = 1'b0; i_wr_en = 1'b0;
  endtask

  task automatic test_timeout();
    lr(1'b0, 32'h9000);
    for (int k = 1; k <= 4; k++) begin
      n_chk++;
      if (t_rv[0] !== 1'b1) $display("FAIL timeout_live k=%0d got %b want 1", k, t_rv[0]); else n_pass++;
      tick();
    end
    n_chk++;
    if ({rv[0], t_rv[0]} !== 2'b10) $display("FAIL timeout_expire got %b want 10", {rv[0], t_rv[0]});
    else n_pass++;
    lr(1'b0, 32'h9000);
    tick(); tick(); tick();
    sc(1'b0, 32'h9000, 1'b1);
    n_chk++;
    if ({t_done, t_gnt} !== 2'b11) $display("FAIL timeout_sc_last got %b want 11", {t_done, t_gnt});
    else n_pass++;
    lr(1'b0, 32'h9000);
    tick(); tick(); tick(); tick();
    sc(1'b0, 32'h9000, 1'b1);
    n_chk++;
    if ({t_done, t_gnt} !== 2'b10) $display("FAIL timeout_sc_late got %b want 10", {t_done, t_gnt});
    else n_pass++;
    lr(1'b0, 32'h0A000);
    tick(); tick(); tick();
    lr(1'b0, 32'h0A000);
    n_chk++;
    if (t_rv[0] !== 1'b1) $display("FAIL timeout_relr got %b want 1", t_rv[0]); else n_pass++;
    tick(); tick(); tick();
    n_chk++;
    if (t_rv[0] !== 1'b1) $display("FAIL timeout_relr_end got %b want 1", t_rv[0]); else n_pass++;
    tick();
    n_chk++;
    if (t_rv[0] !== 1'b0) $display("FAIL timeout_relr_exp got %b want 0", t_rv[0]); else n_pass++;
  endtask

  task automatic test_simultaneous();
    lr(1'b1, 32'h4000);
    i_lr = 1'b1; i_id = 1'b1; i_addr = 32'h4000; i_wr_en = 1'b1; i_wr_addr = 32'h4000;
    tick();
    i_lr = 1'b0; i_wr_en = 1'b0;
    n_chk++;
    if (rv[1] !== 1'b1) $display("FAIL lr_snoop got %b want 1", rv[1]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    lr(1'b0, 32'h6000);
    lr(1'b1, 32'h6000);
    sc(1'b0, 32'h6000, 1'b1);
    n_chk++;
    if (rv !== 2'b10) $display("FAIL b2b_indep got %b want 10", rv); else n_pass++;
    sc(1'b1, 32'h6000, 1'b1);
    sc(1'b1, 32'h6000, 1'b0);
    lr(1'b0, 32'h7000);
    sc(1'b0, 32'h7000, 1'b1);
    lr(1'b1, 32'h7000);
    n_chk++;
    if (rv !== 2'b10) $display("FAIL b2b_sc_lr got %b want 10", rv); else n_pass++;
  endtask

  task automatic test_reset_mid();
    lr(1'b0, 32'h8000);
    i_rst = 1'b1; i_sc = 1'b1; i_id = 1'b0; i_addr = 32'h8000;
    tick();
    i_rst = 1'b0; i_sc = 1'b0;
    n_chk++;
    if ({done, t_done, rv, t_rv} !== 6'b0) $display("FAIL reset_mid got %b want 000000", {done, t_done, rv, t_rv});
    else n_pass++;
    sc(1'b0, 32'h8000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_granule();
    test_snoop();
    test_timeout();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    tick(); tick();
    n_chk++;
    if (q.size() != 0) $display("FAIL sb_drain got %0d want 0", q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
